// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the MIPS fetch stage.
// Package only: no latency or backpressure of its own.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
    localparam logic [31:0] HALT_ADDR    = 32'h00000000;
    localparam logic [31:0] PC_INCR      = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mips_cpu_delay_slot.sv
// Branch-delay-slot tracker and next-PC mux; next PC is combinational in the accept cycle.
// No backpressure of its own: state advances only when the top asserts accept.
module mips_cpu_delay_slot #(
    parameter logic [31:0] RESET_VECTOR = mips_cpu_pkg::RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = mips_cpu_pkg::HALT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] nxt_pc_val,
    output logic        take_halt
);
    import mips_cpu_pkg::*;

    logic        bt_pending;
    logic [31:0] bt_reg;
    logic [31:0] pc_hold;
    logic [31:0] seq_pc;
    logic [31:0] sel_pc;

    // Modulo-2^32 increment: the top of memory wraps to 0 without halting.
    assign seq_pc = instr_pc + PC_INCR;

    always_comb begin
        sel_pc = seq_pc;
        if (bt_pending) begin
            sel_pc = bt_reg;
        end
    end

    assign nxt_pc_val = accept ? sel_pc : pc_hold;
    assign take_halt  = accept & bt_pending & (bt_reg == HALT_ADDR);

    // A redirect seen while a target is already pending is dropped: the first target wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bt_pending <= 1'b0;
            bt_reg     <= 32'h0;
            pc_hold    <= RESET_VECTOR;
        end else if (accept) begin
            pc_hold <= sel_pc;
            if (bt_pending) begin
                bt_pending <= 1'b0;
            end else if (redirect_valid) begin
                bt_reg     <= redirect_target;
                bt_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_cpu_fetch.sv
// MIPS instruction fetch: Avalon read, instruction register, PC-load strobe; 2 cycles/instr at zero wait.
// Holds in FETCH while mem_waitrequest=1 and in ISSUE while stall=1; stops for good after a jump to HALT_ADDR.
module mips_cpu_fetch #(
    parameter logic [31:0] RESET_VECTOR = mips_cpu_pkg::RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = mips_cpu_pkg::HALT_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cur_pc_val,
    output logic [31:0] nxt_pc_val,
    output logic        pc_ctrl,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        instr_valid,
    output logic [31:0] instr_word,
    output logic [31:0] instr_pc,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        active
);
    import mips_cpu_pkg::*;

    fetch_state_t state;
    fetch_state_t next_state;
    logic         accept;
    logic         take_halt;

    assign mem_address    = word_align(cur_pc_val);
    assign mem_byteenable = 4'hF;
    assign accept         = instr_valid & ~stall;
    assign pc_ctrl        = accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:   if (!mem_waitrequest) next_state = ISSUE;
            ISSUE:   if (accept)           next_state = take_halt ? HALTED : FETCH;
            HALTED:  next_state = HALTED;
            default: next_state = FETCH;
        endcase
    end

    // reset gates mem_read directly so an in-flight read is dropped in the cycle reset rises.
    always_comb begin
        mem_read    = 1'b0;
        instr_valid = 1'b0;
        active      = 1'b1;
        case (state)
            FETCH:   mem_read    = ~reset;
            ISSUE:   instr_valid = 1'b1;
            HALTED:  active      = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_word <= 32'h0;
            instr_pc   <= 32'h0;
        end else if (state == FETCH && !mem_waitrequest) begin
            instr_word <= mem_readdata;
            instr_pc   <= cur_pc_val;
        end
    end

    mips_cpu_delay_slot #(
        .RESET_VECTOR (RESET_VECTOR),
        .HALT_ADDR    (HALT_ADDR)
    ) u_delay_slot (
        .clk             (clk),
        .reset           (reset),
        .accept          (accept),
        .instr_pc        (instr_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .nxt_pc_val      (nxt_pc_val),
        .take_halt       (take_halt)
    );

endmodule

// File: tb/tb_mips_cpu_fetch.sv
// Directed bench for mips_cpu_fetch with a behavioural PC register driving cur_pc_val.
module tb_mips_cpu_fetch;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk;
    logic        reset;
    logic [31:0] cur_pc;
    logic [31:0] nxt_pc_val;
    logic        pc_ctrl;
    logic [31:0] mem_address;
    logic        mem_read;
    logic [3:0]  mem_byteenable;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        instr_valid;
    logic [31:0] instr_word;
    logic [31:0] instr_pc;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        active;

    int total;
    int bad;

    mips_cpu_fetch dut (
        .clk             (clk),
        .reset           (reset),
        .cur_pc_val      (cur_pc),
        .nxt_pc_val      (nxt_pc_val),
        .pc_ctrl         (pc_ctrl),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_byteenable  (mem_byteenable),
        .mem_waitrequest (mem_waitrequest),
        .mem_readdata    (mem_readdata),
        .instr_valid     (instr_valid),
        .instr_word      (instr_word),
        .instr_pc        (instr_pc),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .active          (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] rd;
        logic        stl;
        logic        rv;
        logic [31:0] rt;
        logic        e_mr;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_ipc;
        logic [31:0] e_iw;
        logic        e_pcc;
        logic [31:0] e_nxt;
        logic        e_act;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock; the PC register model loads nxt_pc_val when pc_ctrl was high before the edge.
    task automatic cyc();
        logic        ld;
        logic [31:0] nv;
        ld = pc_ctrl;
        nv = nxt_pc_val;
        @(posedge clk);
        #1;
        if (ld) cur_pc = nv;
    endtask

    task automatic drive(input logic wr, input logic [31:0] rd, input logic stl,
                         input logic rv, input logic [31:0] rt);
        mem_waitrequest = wr;
        mem_readdata    = rd;
        stall           = stl;
        redirect_valid  = rv;
        redirect_target = rt;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        cur_pc = RV;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        //          wr  rd            stl rv  rt            mr  addr          iv  ipc           iw            pcc nxt           act
        tbl[0]  = '{0, 32'h24020005, 0, 0, 32'h0,        1, 32'hBFC00000, 0, 32'h0,        32'h0,        0, 32'hBFC00000, 1};
        tbl[1]  = '{0, 32'h0,        0, 0, 32'h0,        0, 32'hBFC00000, 1, 32'hBFC00000, 32'h24020005, 1, 32'hBFC00004, 1};
        tbl[2]  = '{1, 32'hAAAAAAAA, 0, 0, 32'h0,        1, 32'hBFC00004, 0, 32'hBFC00000, 32'h24020005, 0, 32'hBFC00004, 1};
        tbl[3]  = '{1, 32'hBBBBBBBB, 0, 0, 32'h0,        1, 32'hBFC00004, 0, 32'hBFC00000, 32'h24020005, 0, 32'hBFC00004, 1};
        tbl[4]  = '{1, 32'hCCCCCCCC, 0, 0, 32'h0,        1, 32'hBFC00004, 0, 32'hBFC00000, 32'h24020005, 0, 32'hBFC00004, 1};
        tbl[5]  = '{0, 32'h8C080010, 0, 0, 32'h0,        1, 32'hBFC00004, 0, 32'hBFC00000, 32'h24020005, 0, 32'hBFC00004, 1};
        tbl[6]  = '{0, 32'h0,        1, 0, 32'h0,        0, 32'hBFC00004, 1, 32'hBFC00004, 32'h8C080010, 0, 32'hBFC00004, 1};
        tbl[7]  = '{0, 32'h0,        1, 0, 32'h0,        0, 32'hBFC00004, 1, 32'hBFC00004, 32'h8C080010, 0, 32'hBFC00004, 1};
        tbl[8]  = '{0, 32'h0,        0, 0, 32'h0,        0, 32'hBFC00004, 1, 32'hBFC00004, 32'h8C080010, 1, 32'hBFC00008, 1};
        tbl[9]  = '{0, 32'h10000040, 0, 0, 32'h0,        1, 32'hBFC00008, 0, 32'hBFC00004, 32'h8C080010, 0, 32'hBFC00008, 1};
        tbl[10] = '{0, 32'h0,        0, 1, 32'hBFC00100, 0, 32'hBFC00008, 1, 32'hBFC00008, 32'h10000040, 1, 32'hBFC0000C, 1};
        tbl[11] = '{0, 32'h00000000, 0, 1, 32'hDEAD0000, 1, 32'hBFC0000C, 0, 32'hBFC00008, 32'h10000040, 0, 32'hBFC0000C, 1};
        tbl[12] = '{0, 32'h0,        0, 1, 32'h12345678, 0, 32'hBFC0000C, 1, 32'hBFC0000C, 32'h00000000, 1, 32'hBFC00100, 1};
        tbl[13] = '{0, 32'h08000000, 0, 0, 32'h0,        1, 32'hBFC00100, 0, 32'hBFC0000C, 32'h00000000, 0, 32'hBFC00100, 1};
        tbl[14] = '{0, 32'h0,        0, 0, 32'h0,        0, 32'hBFC00100, 1, 32'hBFC00100, 32'h08000000, 1, 32'hBFC00104, 1};
        tbl[15] = '{0, 32'h08000000, 0, 0, 32'h0,        1, 32'hBFC00104, 0, 32'hBFC00100, 32'h08000000, 0, 32'hBFC00104, 1};
        tbl[16] = '{0, 32'h0,        0, 1, 32'h00000000, 0, 32'hBFC00104, 1, 32'hBFC00104, 32'h08000000, 1, 32'hBFC00108, 1};
        tbl[17] = '{0, 32'h00000000, 0, 0, 32'h0,        1, 32'hBFC00108, 0, 32'hBFC00104, 32'h08000000, 0, 32'hBFC00108, 1};
        tbl[18] = '{0, 32'h0,        0, 0, 32'h0,        0, 32'hBFC00108, 1, 32'hBFC00108, 32'h00000000, 1, 32'h00000000, 1};
        tbl[19] = '{0, 32'h0,        0, 0, 32'h0,        0, 32'h00000000, 0, 32'hBFC00108, 32'h00000000, 0, 32'h00000000, 0};

        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset  = 1'b1;
        cur_pc = RV;
        @(posedge clk);
        #1;
        chk("rst_mem_read", {31'h0, mem_read}, 32'd0);
        chk("rst_pc_ctrl", {31'h0, pc_ctrl}, 32'd0);
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'd0);
        chk("rst_instr_word", instr_word, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_nxt_pc", nxt_pc_val, RV);
        chk("rst_active", {31'h0, active}, 32'd1);
        chk("byteenable", {28'h0, mem_byteenable}, 32'hF);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].wr, tbl[i].rd, tbl[i].stl, tbl[i].rv, tbl[i].rt);
            #1;
            chk($sformatf("v%0d_mem_read", i), {31'h0, mem_read}, {31'h0, tbl[i].e_mr});
            chk($sformatf("v%0d_mem_address", i), mem_address, tbl[i].e_addr);
            chk($sformatf("v%0d_instr_valid", i), {31'h0, instr_valid}, {31'h0, tbl[i].e_iv});
            chk($sformatf("v%0d_instr_pc", i), instr_pc, tbl[i].e_ipc);
            chk($sformatf("v%0d_instr_word", i), instr_word, tbl[i].e_iw);
            chk($sformatf("v%0d_pc_ctrl", i), {31'h0, pc_ctrl}, {31'h0, tbl[i].e_pcc});
            chk($sformatf("v%0d_nxt_pc", i), nxt_pc_val, tbl[i].e_nxt);
            chk($sformatf("v%0d_active", i), {31'h0, active}, {31'h0, tbl[i].e_act});
            cyc();
        end

        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h00000040);
            #1;
            chk($sformatf("halt%0d_mem_read", i), {31'h0, mem_read}, 32'd0);
            chk($sformatf("halt%0d_active", i), {31'h0, active}, 32'd0);
            chk($sformatf("halt%0d_pc_ctrl", i), {31'h0, pc_ctrl}, 32'd0);
            cyc();
        end

        // Reset releases HALTED; then leave a branch target pending and reset mid-FETCH.
        do_reset();
        drive(1'b0, 32'h11111111, 1'b0, 1'b0, 32'h0);
        #1;
        chk("r1_active", {31'h0, active}, 32'd1);
        chk("r1_addr", mem_address, RV);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hBFC00200);
        #1;
        chk("r1_branch_nxt", nxt_pc_val, 32'hBFC00004);
        cyc();
        drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("r1_pre_mem_read", {31'h0, mem_read}, 32'd1);
        chk("r1_pre_addr", mem_address, 32'hBFC00004);
        #2;
        reset = 1'b1;
        #1;
        chk("r1_abort_mem_read", {31'h0, mem_read}, 32'd0);
        chk("r1_abort_instr_valid", {31'h0, instr_valid}, 32'd0);
        chk("r1_abort_nxt", nxt_pc_val, RV);
        cur_pc = RV;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 32'h22222222, 1'b0, 1'b0, 32'h0);
        #1;
        chk("r2_mem_read", {31'h0, mem_read}, 32'd1);
        chk("r2_addr", mem_address, RV);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("r2_iw", instr_word, 32'h22222222);
        chk("r2_ipc", instr_pc, RV);
        chk("r2_nxt", nxt_pc_val, 32'hBFC00004);
        cyc();
        #1;
        chk("r2_addr2", mem_address, 32'hBFC00004);
        cyc();
        #1;
        chk("r2_no_stale_target", nxt_pc_val, 32'hBFC00008);
        cyc();

        // Sequential wrap at the top of the address space must not halt.
        cur_pc = 32'hFFFFFFFC;
        #1;
        chk("wrap_addr", mem_address, 32'hFFFFFFFC);
        cyc();
        #1;
        chk("wrap_ipc", instr_pc, 32'hFFFFFFFC);
        chk("wrap_nxt", nxt_pc_val, 32'h00000000);
        chk("wrap_pc_ctrl", {31'h0, pc_ctrl}, 32'd1);
        cyc();
        #1;
        chk("wrap_active", {31'h0, active}, 32'd1);
        chk("wrap_mem_read", {31'h0, mem_read}, 32'd1);
        chk("wrap_addr0", mem_address, 32'h00000000);
        cyc();
        #1;
        chk("wrap_nxt4", nxt_pc_val, 32'h00000004);
        cyc();
        #1;
        chk("wrap_still_active", {31'h0, active}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_cpu_fetch.md
Name: mips_cpu_fetch

Overview:
- Instruction-fetch stage that sits directly upstream of the PC register.
- Reads the current PC, issues an Avalon-MM instruction read and holds the returned word for decode.
- On each accepted instruction, drives nxt_pc_val and pulses pc_ctrl so the PC register loads the next address.
- Owns MIPS branch-delay-slot sequencing and halt-on-jump-to-zero, so the PC register only ever sees plain loads (pc_write_cond tied 0).

Parameters:
- RESET_VECTOR, 32'hBFC00000: first fetch address; value of nxt_pc_val in reset.
- HALT_ADDR, 32'h00000000: target address that stops fetching once taken.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cur_pc_val  in  32  current PC from the PC register.
- nxt_pc_val  out  32  address for the PC register to load.
- pc_ctrl  out  1  one-cycle load strobe to the PC register.
- mem_address  out  32  Avalon instruction address, equal to {cur_pc_val[31:2],2'b00}.
- mem_read  out  1  Avalon read request.
- mem_byteenable  out  4  constant 4'hF.
- mem_waitrequest  in  1  Avalon stall; readdata is valid in the cycle this is low while mem_read=1.
- mem_readdata  in  32  instruction word.
- instr_valid  out  1  instr_word and instr_pc are valid for decode.
- instr_word  out  32  fetched instruction.
- instr_pc  out  32  address of instr_word.
- stall  in  1  decode not ready; instruction not accepted this cycle.
- redirect_valid  in  1  the instruction accepted this cycle is a taken branch or jump.
- redirect_target  in  32  branch/jump destination; sampled with redirect_valid.
- active  out  1  high until halt.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: mem_read=0, pc_ctrl=0, instr_valid=0, instr_word=0, instr_pc=0, nxt_pc_val=RESET_VECTOR, active=1.
  - Internal: bt_pending=0, bt_reg=0. State goes to FETCH.
  - Assertion mid-transaction aborts it immediately (mem_read drops in the same cycle); no partial capture.
- States: FETCH, ISSUE, HALTED.
- FETCH:
  - mem_read=1 with mem_address held stable while mem_waitrequest=1.
  - When mem_waitrequest=0: capture instr_word<=mem_readdata and instr_pc<=cur_pc_val, then go to ISSUE.
- ISSUE:
  - instr_valid=1.
  - Accept = instr_valid & !stall.
  - On accept: pc_ctrl=1 (combinational, this cycle only), then next state is FETCH or HALTED.
  - While stall=1: all outputs hold and pc_ctrl=0.
- Next-PC selection on accept (bt_pending checked first):
  - bt_pending=1: the accepted instruction is the delay slot. nxt_pc_val=bt_reg, clear bt_pending. If bt_reg==HALT_ADDR, go to HALTED instead of FETCH.
  - bt_pending=0 and redirect_valid=1: nxt_pc_val=instr_pc+4 (delay slot), bt_reg<=redirect_target, bt_pending<=1.
  - Otherwise: nxt_pc_val=instr_pc+4.
  - Adder is 32-bit modulo; 32'hFFFFFFFC wraps to 0 with no halt, because halt applies only to a taken target.
  - redirect_valid is ignored outside accept cycles.
  - redirect_valid is ignored when bt_pending=1 (branch in delay slot is unsupported; first target wins).
- HALTED:
  - active=0, mem_read=0, instr_valid=0, pc_ctrl=0. Held until reset.
- Latency:
  - Zero-wait memory: 2 cycles per instruction (FETCH 1 cycle, ISSUE 1 cycle).
  - Each waitrequest cycle adds 1 cycle; each stall cycle adds 1 cycle.
- Outside accept cycles, nxt_pc_val holds its last driven value; pc_ctrl is never high in FETCH or HALTED.

Decomposition:
- mips_cpu_pkg holds: fetch_state_t enum {FETCH, ISSUE, HALTED}, RESET_VECTOR, HALT_ADDR, PC_INCR=32'd4.
- One sub-module, mips_cpu_delay_slot:
  - Contents: bt_reg and bt_pending flops plus the next-PC mux.
  - Inputs: accept, instr_pc, redirect_valid, redirect_target.
  - Outputs: nxt_pc_val, take_halt.
- The top level keeps the FSM, the Avalon interface and the instruction register.

Test Plan:
- Reset then zero-wait memory returning 32'h24020005: mem_read=1 and mem_address=BFC00000 in the first cycle; next cycle instr_valid=1, instr_pc=BFC00000, pc_ctrl=1, nxt_pc_val=BFC00004.
- mem_waitrequest high for 3 cycles in FETCH: mem_address and mem_read stable for 4 cycles, instr_valid=0 and pc_ctrl=0 throughout; capture in the 4th cycle.
- Accept at instr_pc=BFC00008 with redirect_valid=1, redirect_target=BFC00100: nxt_pc_val=BFC0000C. Next accept (delay slot BFC0000C): nxt_pc_val=BFC00100. Following accept: BFC00104.
- stall=1 for 2 ISSUE cycles: instr_word and instr_pc unchanged, pc_ctrl=0 both cycles; pc_ctrl pulses once in the cycle stall drops.
- Jump to 0 (redirect_target=0): delay slot is fetched and accepted with nxt_pc_val=0, then active=0; mem_read stays 0 for 20 further cycles.
- reset asserted mid-FETCH with mem_waitrequest=1: mem_read=0 and instr_valid=0 in the same cycle. After release, the first fetch is at BFC00000 and bt_pending is cleared: a pre-reset branch target is never taken.
